// File: rtl/pdm_mic_rx_if.sv
// Output sample stream of the PDM microphone receiver.
// The producer presents a show-ahead head word and the consumer accepts it
// with ready while valid is high.
interface pdm_mic_rx_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0] dout;
    logic             dout_ch;
    logic             valid;
    logic             ready;

    modport master (
        output dout,
        output dout_ch,
        output valid,
        input  ready
    );

    modport slave (
        input  dout,
        input  dout_ch,
        input  valid,
        output ready
    );
endinterface

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver.
// Derives the microphone clock from clk and samples left (end of the high
// phase) and optionally right (end of the low phase) PDM bits. Each channel
// is decimated by a boxcar ones-count into a signed word, which is queued
// in a small show-ahead FIFO with a sticky overflow flag.
module pdm_mic_rx #(
    parameter int CLK_DIV    = 50,
    parameter int DECIM      = 64,
    parameter int OUT_W      = 16,
    parameter int STEREO     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          mclk,
    output logic          micLRSel,
    input  logic          micData,
    output logic          overflow,
    input  logic          clear_ovf,
    pdm_mic_rx_if.master  out_if
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DECIM);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF      = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [DW-1:0] BIT_LAST      = DW'(DECIM - 1);
    localparam logic [DW:0]   HALF_DECIM    = (DW + 1)'(DECIM / 2);
    localparam logic [PW:0]   DEPTH_C       = (PW + 1)'(FIFO_DEPTH);

    // Widen a (DW+1)-bit two's complement result to the output width.
    function automatic logic [OUT_W-1:0] sign_ext(input logic [DW:0] v);
        logic [OUT_W-1:0] r;
        for (int i = 0; i < OUT_W; i++) begin
            r[i] = (i <= DW) ? v[i] : v[DW];
        end
        return r;
    endfunction

    // Divider state
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_next_s;
    logic           mclk_r;
    logic           mclk_next_s;
    logic [1:0]     samp_s;

    // Per-channel decimator state (index 0 = L, 1 = R)
    logic [DW-1:0]  bitcnt_r [2];
    logic [DW:0]    acc_r    [2];
    logic [DW:0]    ones_s   [2];
    logic [DW:0]    res_s    [2];
    logic [1:0]     done_s;

    // Push request towards the FIFO
    logic           push_s;
    logic [OUT_W:0] push_entry_s;

    // FIFO state
    logic [OUT_W:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]  wptr_r;
    logic [PW-1:0]  rptr_r;
    logic [PW-1:0]  rptr_next_s;
    logic [PW:0]    count_r;
    logic [PW:0]    count_next_s;
    logic [PW:0]    remain_s;
    logic           full_s;
    logic           pop_s;
    logic           wr_s;
    logic           drop_s;
    logic [OUT_W:0] head_next_s;
    logic           valid_next_s;
    logic [OUT_W-1:0] dout_r;
    logic           dout_ch_r;
    logic           valid_r;
    logic           ovf_r;
    logic           ovf_next_s;

    // Divider next state and the two sample strobes.
    always_comb begin
        cnt_next_s = {CW{1'b0}};
        if (!enable) begin
            cnt_next_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
        mclk_next_s = enable && (cnt_next_s < CNT_HALF);
        samp_s[0]   = enable && (cnt_r == CNT_HALF_LAST);
        samp_s[1]   = (STEREO != 0) && enable && (cnt_r == CNT_LAST);
    end

    // Divider counter and registered microphone clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= {CW{1'b0}};
            mclk_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            mclk_r <= mclk_next_s;
        end
    end

    // Ones total including the current bit, and end-of-window detection.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            ones_s[ch] = acc_r[ch] + (DW + 1)'(micData);
            res_s[ch]  = ones_s[ch] - HALF_DECIM;
            done_s[ch] = samp_s[ch] && (bitcnt_r[ch] == BIT_LAST);
        end
    end

    // Per-channel bit counter and accumulator; a finished window restarts at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                bitcnt_r[ch] <= {DW{1'b0}};
                acc_r[ch]    <= {(DW + 1){1'b0}};
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!enable || done_s[ch]) begin
                    bitcnt_r[ch] <= {DW{1'b0}};
                    acc_r[ch]    <= {(DW + 1){1'b0}};
                end else if (samp_s[ch]) begin
                    bitcnt_r[ch] <= bitcnt_r[ch] + DW'(1);
                    acc_r[ch]    <= ones_s[ch];
                end else begin
                    bitcnt_r[ch] <= bitcnt_r[ch];
                    acc_r[ch]    <= acc_r[ch];
                end
            end
        end
    end

    // Select the finished channel word; L and R never finish together.
    always_comb begin
        push_s = done_s[0] || done_s[1];
        if (done_s[1]) begin
            push_entry_s = {1'b1, sign_ext(res_s[1])};
        end else begin
            push_entry_s = {1'b0, sign_ext(res_s[0])};
        end
    end

    // FIFO bookkeeping, registered head prediction and overflow update.
    always_comb begin
        full_s       = (count_r == DEPTH_C);
        pop_s        = valid_r && out_if.ready;
        wr_s         = push_s && (!full_s || pop_s);
        drop_s       = push_s && full_s && !pop_s;
        count_next_s = count_r + (PW + 1)'(wr_s) - (PW + 1)'(pop_s);
        remain_s     = count_r - (PW + 1)'(pop_s);
        rptr_next_s  = pop_s ? (rptr_r + PW'(1)) : rptr_r;
        valid_next_s = (count_next_s != {(PW + 1){1'b0}});
        head_next_s  = {dout_ch_r, dout_r};
        if (remain_s == {(PW + 1){1'b0}}) begin
            if (wr_s) begin
                head_next_s = push_entry_s;
            end else begin
                head_next_s = {dout_ch_r, dout_r};
            end
        end else begin
            head_next_s = mem_r[rptr_next_s];
        end
        if (drop_s) begin
            ovf_next_s = 1'b1;
        end else if (clear_ovf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // FIFO storage, pointers and registered head/valid/overflow outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(OUT_W + 1){1'b0}};
            end
            wptr_r    <= {PW{1'b0}};
            rptr_r    <= {PW{1'b0}};
            count_r   <= {(PW + 1){1'b0}};
            dout_r    <= {OUT_W{1'b0}};
            dout_ch_r <= 1'b0;
            valid_r   <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wptr_r] <= push_entry_s;
                wptr_r        <= wptr_r + PW'(1);
            end else begin
                wptr_r        <= wptr_r;
            end
            rptr_r    <= rptr_next_s;
            count_r   <= count_next_s;
            dout_ch_r <= head_next_s[OUT_W];
            dout_r    <= head_next_s[OUT_W-1:0];
            valid_r   <= valid_next_s;
            ovf_r     <= ovf_next_s;
        end
    end

    assign mclk           = mclk_r;
    assign micLRSel       = 1'b0;
    assign overflow       = ovf_r;
    assign out_if.dout    = dout_r;
    assign out_if.dout_ch = dout_ch_r;
    assign out_if.valid   = valid_r;
endmodule

// File: tb/tb_pdm_mic_rx.sv
// Bench for pdm_mic_rx: a mono and a stereo instance, both CLK_DIV=4,
// DECIM=8, OUT_W=16, FIFO_DEPTH=4. Expected words go into per-instance
// queues; monitors pop and compare whenever a word is accepted.
module tb_pdm_mic_rx;
    logic clk = 1'b0;
    logic reset;
    logic m_en, m_mic, m_clr;
    logic s_en, s_clr;
    wire  m_mclk, m_lr, m_ovf;
    wire  s_mclk, s_lr, s_ovf;
    wire  s_mic;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] m_q [$];
    logic [16:0] s_q [$];
    logic [16:0] m_exp;
    logic [16:0] s_exp;

    logic [7:0]  vpat [0:7] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'h0F, 8'h07, 8'h7F, 8'h01};
    logic [15:0] vexp [0:7] = '{16'h0004, 16'hFFFC, 16'h0000, 16'h0000,
                                16'h0000, 16'hFFFF, 16'h0003, 16'hFFFD};

    pdm_mic_rx_if #(.OUT_W(16)) m_if ();
    pdm_mic_rx_if #(.OUT_W(16)) s_if ();

    pdm_mic_rx #(.CLK_DIV(4), .DECIM(8), .OUT_W(16), .STEREO(0), .FIFO_DEPTH(4)) u_mono (
        .clk(clk), .reset(reset), .enable(m_en), .mclk(m_mclk), .micLRSel(m_lr),
        .micData(m_mic), .overflow(m_ovf), .clear_ovf(m_clr), .out_if(m_if.master)
    );

    pdm_mic_rx #(.CLK_DIV(4), .DECIM(8), .OUT_W(16), .STEREO(1), .FIFO_DEPTH(4)) u_st (
        .clk(clk), .reset(reset), .enable(s_en), .mclk(s_mclk), .micLRSel(s_lr),
        .micData(s_mic), .overflow(s_ovf), .clear_ovf(s_clr), .out_if(s_if.master)
    );

    // High at every L point, low at every R point.
    assign s_mic = s_mclk;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive nb L-bit slots (4 clk each) of pat, LSB first, on the mono DUT.
    task automatic l_bits(input logic [7:0] pat, input int nb, input bit do_push,
                          input logic [15:0] exp);
        if (do_push) m_q.push_back({1'b0, exp});
        for (int i = 0; i < nb; i++) begin
            m_mic = pat[i];
            tick(4);
        end
    endtask

    // Mono output monitor.
    always @(negedge clk) begin
        if (reset && m_if.valid && m_if.ready) begin
            n_cmp++;
            if (m_q.size() == 0) begin
                n_bad++;
                $display("FAIL mono_out: got %h/ch%0d, required no word", m_if.dout, m_if.dout_ch);
            end else begin
                m_exp = m_q.pop_front();
                if ({m_if.dout_ch, m_if.dout} !== m_exp) begin
                    n_bad++;
                    $display("FAIL mono_out: got %h/ch%0d, required %h/ch%0d",
                             m_if.dout, m_if.dout_ch, m_exp[15:0], m_exp[16]);
                end
            end
        end
    end

    // Stereo output monitor.
    always @(negedge clk) begin
        if (reset && s_if.valid && s_if.ready) begin
            n_cmp++;
            if (s_q.size() == 0) begin
                n_bad++;
                $display("FAIL st_out: got %h/ch%0d, required no word", s_if.dout, s_if.dout_ch);
            end else begin
                s_exp = s_q.pop_front();
                if ({s_if.dout_ch, s_if.dout} !== s_exp) begin
                    n_bad++;
                    $display("FAIL st_out: got %h/ch%0d, required %h/ch%0d",
                             s_if.dout, s_if.dout_ch, s_exp[15:0], s_exp[16]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        m_en = 1'b0; m_mic = 1'b0; m_clr = 1'b0;
        s_en = 1'b0; s_clr = 1'b0;
        m_if.ready = 1'b1;
        s_if.ready = 1'b1;
        #2 reset = 1'b0;
        tick(3);
        chk("rst_valid", 32'(m_if.valid), 32'h0);
        chk("rst_dout", 32'(m_if.dout), 32'h0);
        chk("rst_ovf", 32'(m_ovf), 32'h0);
        chk("rst_mclk", 32'(m_mclk), 32'h0);
        chk("rst_lrsel", 32'(m_lr), 32'h0);

        // Directed windows with ready=1.
        @(posedge clk);
        #1 reset = 1'b1;
        m_en = 1'b1;
        chk("idle_valid", 32'(m_if.valid), 32'h0);
        for (int v = 0; v < 8; v++) begin
            l_bits(vpat[v], 8, 1'b1, vexp[v]);
        end

        // Partial window discarded by enable low.
        l_bits(8'hFF, 5, 1'b0, 16'h0000);
        m_en = 1'b0;
        tick(6);
        chk("dis_mclk", 32'(m_mclk), 32'h0);
        chk("dis_valid", 32'(m_if.valid), 32'h0);
        m_en = 1'b1;
        l_bits(8'h00, 8, 1'b1, 16'hFFFC);

        // Overflow: fifth word dropped while ready=0.
        m_if.ready = 1'b0;
        l_bits(8'hFF, 8, 1'b1, 16'h0004);
        l_bits(8'h00, 8, 1'b1, 16'hFFFC);
        l_bits(8'h7F, 8, 1'b1, 16'h0003);
        l_bits(8'h01, 8, 1'b1, 16'hFFFD);
        l_bits(8'h55, 8, 1'b0, 16'h0000);
        chk("full_ovf", 32'(m_ovf), 32'h1);
        chk("full_valid", 32'(m_if.valid), 32'h1);
        m_en = 1'b0;
        m_if.ready = 1'b1;
        tick(8);
        chk("drain_valid", 32'(m_if.valid), 32'h0);
        chk("hold_dout", 32'(m_if.dout), 32'h0000FFFD);
        chk("ovf_sticky", 32'(m_ovf), 32'h1);
        m_clr = 1'b1;
        tick(1);
        m_clr = 1'b0;
        chk("ovf_cleared", 32'(m_ovf), 32'h0);

        // Asynchronous reset mid-window with two entries queued.
        m_if.ready = 1'b0;
        m_en = 1'b1;
        l_bits(8'hFF, 8, 1'b0, 16'h0000);
        l_bits(8'hFF, 8, 1'b0, 16'h0000);
        tick(9);
        chk("pre_rst_valid", 32'(m_if.valid), 32'h1);
        chk("pre_rst_mclk", 32'(m_mclk), 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(m_if.valid), 32'h0);
        chk("arst_dout", 32'({m_if.dout_ch, m_if.dout}), 32'h0);
        chk("arst_mclk", 32'(m_mclk), 32'h0);
        chk("arst_ovf", 32'(m_ovf), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        m_if.ready = 1'b1;
        l_bits(8'h03, 8, 1'b1, 16'hFFFE);
        l_bits(8'h00, 8, 1'b1, 16'hFFFC);
        m_en = 1'b0;
        tick(4);

        // Stereo: L high, R low.
        for (int p = 0; p < 3; p++) begin
            s_q.push_back({1'b0, 16'h0004});
            s_q.push_back({1'b1, 16'hFFFC});
        end
        s_en = 1'b1;
        tick(100);
        s_en = 1'b0;
        tick(8);
        chk("st_ovf", 32'(s_ovf), 32'h0);
        chk("st_lrsel", 32'(s_lr), 32'h0);

        chk("mono_q_left", 32'(m_q.size()), 32'h0);
        chk("st_q_left", 32'(s_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pdm_mic_rx.md
# pdm_mic_rx

Parametrised PDM microphone receiver, the successor to the 8-bit shift-and-latch microphone capture in the audio peripheral. It generates the microphone clock from the system clock and samples one or two PDM channels on a shared data line. Each channel is decimated with a boxcar ones-count filter into signed PCM words, and the words are buffered in a small FIFO with a valid/ready output handshake. It feeds the PWM playback path and any bus-side reader.

## Interface
- CLK_DIV, 50: clk cycles per mclk period; even, ≥4.
- DECIM, 64: PDM bits per output sample per channel; power of 2, 4..256.
- OUT_W, 16: output sample width; must be ≥ log2(DECIM)+1.
- STEREO, 0: 0 = left channel only; 1 = left and right channels.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable.
- mclk  out  1  microphone clock, registered.
- micLRSel  out  1  microphone L/R select; constant 0.
- micData  in  1  shared PDM data line.
- dout  out  OUT_W  head-of-FIFO sample, signed two's complement.
- dout_ch  out  1  channel of the head sample: 0 = L, 1 = R.
- valid  out  1  FIFO not empty.
- ready  in  1  consumer accepts the head sample.
- overflow  out  1  sticky flag: a sample was dropped.
- clear_ovf  in  1  clears overflow.

## Operation
- Divider: cnt counts 0..CLK_DIV-1 and wraps. mclk=1 for cnt < CLK_DIV/2, else 0.
- L sample point: the cycle with cnt = CLK_DIV/2-1 (end of the high phase).
- R sample point: the cycle with cnt = CLK_DIV-1 (end of the low phase). R is sampled only when STEREO=1.
- micData is sampled directly at each sample point. Each channel has its own bit counter (0..DECIM-1) and ones accumulator (log2(DECIM)+1 bits).
- On a channel's DECIM-th bit:
  - result = ones_total − DECIM/2, where ones_total includes the current bit.
  - The result is sign-extended to OUT_W and pushed as {ch, result}.
  - The accumulator and bit counter restart at 0 in the same edge; no bit is lost.
- Output range is −DECIM/2..+DECIM/2.
- FIFO is show-ahead: dout and dout_ch present the head entry whenever valid=1. A pop occurs when valid && ready.
- Full FIFO:
  - A push with no pop in the same cycle is dropped and overflow is set.
  - A push together with a pop is accepted.
- L and R pushes never coincide because they are half an mclk period apart. Output order is L then R.
- overflow clears on clear_ovf=1. If a new drop occurs in the same cycle as clear_ovf, overflow stays 1.
- enable=0:
  - cnt is held at 0 and mclk is 0.
  - Accumulators and bit counters are cleared, so a partial window is discarded.
  - The FIFO stays readable and poppable.
- enable rising starts a fresh window: the first L sample point falls CLK_DIV/2 cycles after enable goes high.

## Timing
- Reset (asynchronous, immediate): mclk=0, micLRSel=0, valid=0, dout=0, dout_ch=0, overflow=0. The FIFO, counters and accumulators are all cleared.
- Push latency: the FIFO is written at the clk edge that samples the DECIM-th bit. valid=1 from the next cycle.
- Pop: the head advances at the edge where valid && ready. A new head or valid=0 is visible the next cycle.
- When the FIFO empties, dout holds its last value. dout is 0 only after reset.
- Output rate per channel: one word every DECIM×CLK_DIV clk cycles.

## Test plan
- Reset low mid-window with FIFO holding 2 entries: valid, overflow, mclk and dout go to 0 without a clock edge. After release with enable=1, the first L sample occurs CLK_DIV/2 cycles later.
- Mono, CLK_DIV=4, DECIM=8, OUT_W=16, micData=1, ready=1: dout=0x0004, dout_ch=0; valid pulses once every 32 clk. With micData=0, dout=0xFFFC.
- Mono, micData alternating 1/0 on successive L sample points: dout=0x0000 every window.
- STEREO=1, micData=1 at L points and 0 at R points: the FIFO yields 0x0004/ch0, then 0xFFFC/ch1, repeating.
- ready=0, FIFO_DEPTH=4, constant input: after 4 pushes valid stays 1, the 5th word is dropped and overflow=1. The FIFO holds the first 4 words, which pop in order once ready=1. Pulsing clear_ovf returns overflow to 0.
- enable dropped after 5 of 8 L bits, then raised: no partial word is pushed. The next word appears after 8 full L bits, with its value computed from new bits only.
